// File: rtl/seq_match_ctrl_if.sv
// rtl/seq_match_ctrl_if.sv - configuration, run-control and serial-stream bundle for seq_match_ctrl
// Ports (master = bus-side controller, slave = seq_match_ctrl):
//   cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_target/cfg_err : configuration handshake
//   start/abort                                                : run control
//   data_valid/data                                            : 1-bit serial stream
//   flag/match_cnt/busy/done                                   : detection status
interface seq_match_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             data_valid;
    logic             data;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, data_valid, data,
        input  cfg_ready, cfg_err, flag, match_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, data_valid, data,
        output cfg_ready, cfg_err, flag, match_cnt, busy, done
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - programmable non-overlapping serial pattern detector with run sequencer
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : seq_match_ctrl_if.slave (config handshake, start/abort, serial data, status)
module seq_match_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_match_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] PAT_LIM = LEN_W'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [PAT_W-1:0] win_q, win_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             err_q, err_d;
    logic             busy_q, done_q;

    logic             xfer;
    logic             cfg_legal;
    logic [PAT_W-1:0] win_sh;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    assign xfer      = bus.cfg_valid && (state_q != S_RUN);
    assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= PAT_LIM);
    assign win_sh    = {win_q[PAT_W-2:0], bus.data};
    // Shifting all-ones left by len leaves zeros in the low len bits; len == PAT_W yields all-ones.
    assign mask      = ~({PAT_W{1'b1}} << len_q);
    assign fill_nx   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    // fill_nx already includes this cycle's bit, so a full window is compared right as it completes.
    assign hit       = (fill_nx == len_q) && ((win_sh & mask) == (pat_q & mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        flag_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE, S_READY, S_DONE: begin
                if (xfer) begin
                    // Any transfer, legal or not, takes the cycle and suppresses start.
                    if (cfg_legal) begin
                        pat_d   = bus.cfg_pattern;
                        len_d   = bus.cfg_len;
                        tgt_d   = bus.cfg_target;
                        state_d = S_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.start && (state_q != S_IDLE)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    fill_d  = '0;
                    win_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_READY;
                end else if (bus.data_valid) begin
                    win_d = win_sh;
                    if (hit) begin
                        flag_d = 1'b1;
                        cnt_d  = cnt_inc;
                        fill_d = '0;
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        fill_d = fill_nx;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cfg_ready = (state_q != S_RUN);
    assign bus.cfg_err   = err_q;
    assign bus.flag      = flag_q;
    assign bus.match_cnt = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - directed, table-driven bench for seq_match_ctrl
module tb_seq_match_ctrl;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_match_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_match_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             cv;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] tgt;
        logic             st;
        logic             ab;
        logic             dv;
        logic             d;
        logic             e_flag;
        logic [CNT_W-1:0] e_cnt;
        logic             e_busy;
        logic             e_done;
        logic             e_err;
        logic             e_rdy;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic cv, input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                     input logic [CNT_W-1:0] tgt, input logic st, input logic ab,
                     input logic dv, input logic d, input logic e_flag,
                     input logic [CNT_W-1:0] e_cnt, input logic e_busy, input logic e_done,
                     input logic e_err, input logic e_rdy);
        vec_t x;
        x.cv = cv; x.pat = pat; x.len = len; x.tgt = tgt; x.st = st; x.ab = ab;
        x.dv = dv; x.d = d; x.e_flag = e_flag; x.e_cnt = e_cnt; x.e_busy = e_busy;
        x.e_done = e_done; x.e_err = e_err; x.e_rdy = e_rdy;
        vq.push_back(x);
    endtask

    // One stream bit while running under config (pat, len); only the expected status varies.
    task automatic b(input logic d, input logic e_flag, input logic [CNT_W-1:0] e_cnt);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, d, e_flag, e_cnt, 1, 0, 0, 0);
    endtask

    task automatic drive_idle();
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_target  = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.data_valid  = 1'b0;
        bus.data        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic e_flag, input logic [CNT_W-1:0] e_cnt,
                             input logic e_busy, input logic e_done, input logic e_err,
                             input logic e_rdy);
        logic [12:0] act, exp;
        act = {bus.flag, bus.match_cnt, bus.busy, bus.done, bus.cfg_err, bus.cfg_ready};
        exp = {e_flag, e_cnt, e_busy, e_done, e_err, e_rdy};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got flag=%b cnt=%0d busy=%b done=%b err=%b rdy=%b want flag=%b cnt=%0d busy=%b done=%b err=%b rdy=%b",
                     name, bus.flag, bus.match_cnt, bus.busy, bus.done, bus.cfg_err, bus.cfg_ready,
                     e_flag, e_cnt, e_busy, e_done, e_err, e_rdy);
        end
    endtask

    task automatic cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic [CNT_W-1:0] tgt);
        drive_idle();
        bus.cfg_valid = 1'b1; bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_target = tgt;
        tick();
        drive_idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_values", 0, 8'd0, 0, 0, 0, 1);
        #3 rst = 1'b1;

        // Illegal configs in IDLE; start stays ignored.
        v(1, 8'h17, 4'd0, 8'd0, 0, 0, 0, 0,  0, 8'd0, 0, 0, 1, 1);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0,  0, 8'd0, 0, 0, 0, 1);
        v(1, 8'h17, 4'd9, 8'd0, 0, 0, 0, 0,  0, 8'd0, 0, 0, 1, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 0, 0, 0, 1);
        // 10111, unlimited; overlap-sharing match at bit 9 must not fire.
        v(1, 8'h17, 4'd5, 8'd0, 0, 0, 0, 0,  0, 8'd0, 0, 0, 0, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0); b(0,0,0); b(1,0,0); b(1,0,0); b(1,1,1);
        b(0,0,1); b(1,0,1); b(1,0,1); b(1,0,1);
        v(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0,  0, 8'd1, 0, 0, 0, 1);
        // Two back-to-back matches.
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0); b(0,0,0); b(1,0,0); b(1,0,0); b(1,1,1);
        b(1,0,1); b(0,0,1); b(1,0,1); b(1,0,1); b(1,1,2);
        v(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0,  0, 8'd2, 0, 0, 0, 1);
        // Target 2: DONE after the second match, third pattern ignored.
        v(1, 8'h17, 4'd5, 8'd2, 0, 0, 0, 0,  0, 8'd2, 0, 0, 0, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0); b(0,0,0); b(1,0,0); b(1,0,0); b(1,1,1);
        b(1,0,1); b(0,0,1); b(1,0,1); b(1,0,1);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1,  1, 8'd2, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            v(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, (i == 1) ? 1'b0 : 1'b1,  0, 8'd2, 0, 1, 0, 1);
        // Config from DONE returns to READY with the count held; then gaps inside a pattern.
        v(1, 8'h17, 4'd5, 8'd0, 0, 0, 0, 0,  0, 8'd2, 0, 0, 0, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1,  0, 8'd0, 1, 0, 0, 0);
        b(0,0,0); b(1,0,0);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0); b(1,1,1);
        // Abort on what would be the match edge.
        b(1,0,1); b(0,0,1); b(1,0,1); b(1,0,1);
        v(0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 1,  0, 8'd1, 0, 0, 0, 1);
        // Length 1.
        v(1, 8'h01, 4'd1, 8'd0, 0, 0, 0, 0,  0, 8'd1, 0, 0, 0, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,1,1); b(0,0,1); b(1,1,2);
        v(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0,  0, 8'd2, 0, 0, 0, 1);
        // Full length 8, target 1.
        v(1, 8'hA5, 4'd8, 8'd1, 0, 0, 0, 0,  0, 8'd2, 0, 0, 0, 1);
        v(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0, 0);
        b(1,0,0); b(0,0,0); b(1,0,0); b(0,0,0); b(0,0,0); b(1,0,0); b(0,0,0);
        v(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1,  1, 8'd1, 0, 1, 0, 1);

        foreach (vq[i]) begin
            bus.cfg_valid   = vq[i].cv;
            bus.cfg_pattern = vq[i].pat;
            bus.cfg_len     = vq[i].len;
            bus.cfg_target  = vq[i].tgt;
            bus.start       = vq[i].st;
            bus.abort       = vq[i].ab;
            bus.data_valid  = vq[i].dv;
            bus.data        = vq[i].d;
            tick();
            check_all($sformatf("vec%0d", i), vq[i].e_flag, vq[i].e_cnt, vq[i].e_busy,
                      vq[i].e_done, vq[i].e_err, vq[i].e_rdy);
        end
        drive_idle();

        // Saturation: 256 length-1 matches leave the count at all-ones, flag still pulsing.
        cfg(8'h01, 4'd1, 8'd0);
        bus.start = 1'b1;
        tick();
        drive_idle();
        bus.data_valid = 1'b1;
        bus.data       = 1'b1;
        repeat (256) tick();
        check_all("saturate", 1, 8'd255, 1, 0, 0, 0);

        // Async reset between edges, right after a match pulse.
        #2 rst = 1'b0;
        #1;
        check_all("async_reset", 0, 8'd0, 0, 0, 0, 1);
        drive_idle();
        #2 rst = 1'b1;
        bus.start = 1'b1;
        tick();
        check_all("start_after_reset", 0, 8'd0, 0, 0, 0, 1);
        drive_idle();
        cfg(8'h17, 4'd5, 8'd0);
        bus.start = 1'b1;
        tick();
        drive_idle();
        check_all("start_after_cfg", 0, 8'd0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
